jt7759_feeder: RTL and testbench

JT7759_FEEDER -- requirements
Module: jt7759_feeder

---
 rtl/jt7759_pkg.sv | 26 ++
 rtl/jt7759_strobe.sv | 34 +++
 rtl/jt7759_feeder.sv | 146 ++++++++++++++
 tb/tb_jt7759_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_pkg.sv
// Shared definitions for the jt7759 slave-mode feeder: one-hot FSM states,
// sample table base offset and strobe polarity constants.
package jt7759_pkg;

  typedef enum logic [8:0] {
    IDLE     = 9'h001,
    TBL_HI   = 9'h002,
    TBL_LO   = 9'h004,
    START    = 9'h008,
    WAIT_BSY = 9'h010,
    WAIT_DRQ = 9'h020,
    FETCH    = 9'h040,
    WRITE    = 9'h080,
    RELEASE  = 9'h100
  } state_t;

  localparam logic [16:0] TBL_BASE = 17'd5;
  localparam logic        STB_ACT  = 1'b0;
  localparam logic        STB_IDLE = 1'b1;

  // Each sample owns a two-byte big-endian pointer entry after the header
  function automatic logic [16:0] tbl_addr(input logic [7:0] s);
    return {8'd0, s, 1'b0} + TBL_BASE;
  endfunction

endpackage

// File: rtl/jt7759_strobe.sv
// Active-low strobe generator: a fire request drives the line low for exactly
// WRW cycles; last flags the final low cycle so the FSM can move on with it.
module jt7759_strobe import jt7759_pkg::*; #(
  parameter int WRW = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic fire,
  input  logic clr,
  output logic n,
  output logic last
);

  logic [3:0] cnt;

  assign last = (n == STB_ACT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n   <= STB_IDLE;
      cnt <= 4'd0;
    end else if (clr) begin
      n   <= STB_IDLE;
      cnt <= 4'd0;
    end else if (fire) begin
      n   <= STB_ACT;
      cnt <= 4'(WRW - 1);
    end else if (n == STB_ACT) begin
      if (cnt == 4'd0) n <= STB_IDLE;
      else             cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/jt7759_feeder.sv
// Feeds sample bytes from memory to a slave-mode jt7759 ADPCM chip: reads the
// sample pointer table, starts the chip, then answers each DRQ with one byte.
module jt7759_feeder import jt7759_pkg::*; #(
  parameter int WRW = 4,
  parameter int TOW = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        play,
  input  logic [7:0]  snd,
  input  logic        stop,
  output logic        busy,
  output logic        err,
  output logic        cs,
  output logic        stn,
  output logic        wrn,
  output logic [7:0]  dout,
  input  logic        drqn,
  input  logic        busyn,
  output logic        rom_cs,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  state_t         state, state_d;
  logic [7:0]     snd_l, hi_l;
  logic [16:0]    ptr;
  logic [TOW-1:0] wd;
  logic           rd_ok, watched, tmo;
  logic           acc_play, got_hi, got_lo, got_byte, req_drq, fin;
  logic           stn_last, wrn_last;

  assign rd_ok   = rom_cs & rom_ok;
  assign watched = state inside {TBL_HI, TBL_LO, WAIT_BSY, FETCH, RELEASE};
  assign tmo     = watched & (&wd);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    acc_play = 1'b0;
    got_hi   = 1'b0;
    got_lo   = 1'b0;
    got_byte = 1'b0;
    req_drq  = 1'b0;
    fin      = 1'b0;
    if (stop || tmo) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:     if (play) begin acc_play = 1'b1; state_d = TBL_HI; end
        TBL_HI:   if (rd_ok) begin got_hi = 1'b1; state_d = TBL_LO; end
        TBL_LO:   if (rd_ok) begin got_lo = 1'b1; state_d = START; end
        START:    if (stn_last) state_d = WAIT_BSY;
        WAIT_BSY: if (!busyn) state_d = WAIT_DRQ;
        WAIT_DRQ: begin
          // A pending request is served before noticing the chip went idle
          if (!drqn)     begin req_drq = 1'b1; state_d = FETCH; end
          else if (busyn) begin fin = 1'b1; state_d = IDLE; end
        end
        FETCH:    if (rd_ok) begin got_byte = 1'b1; state_d = WRITE; end
        WRITE:    if (wrn_last) state_d = RELEASE;
        RELEASE:  if (drqn) state_d = WAIT_DRQ;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Watchdog restarts on every state change and only runs in stall-prone states
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             wd <= '0;
    else if (state_d != state || !watched) wd <= '0;
    else                                   wd <= wd + TOW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err      <= 1'b0;
      cs       <= 1'b0;
      dout     <= 8'd0;
      rom_cs   <= 1'b0;
      rom_addr <= 17'd0;
      snd_l    <= 8'd0;
      hi_l     <= 8'd0;
      ptr      <= 17'd0;
    end else if (stop || tmo) begin
      cs     <= 1'b0;
      rom_cs <= 1'b0;
      if (!stop) err <= 1'b1;
    end else begin
      if (acc_play) begin
        snd_l    <= snd;
        err      <= 1'b0;
        rom_addr <= tbl_addr(snd);
        rom_cs   <= 1'b1;
      end
      if (got_hi) begin
        hi_l     <= rom_data;
        rom_addr <= rom_addr + 17'd1;
        rom_cs   <= 1'b0;
      end
      // rom_cs is dropped for one cycle between the two table reads
      if (state == TBL_LO && !rom_cs) rom_cs <= 1'b1;
      if (got_lo) begin
        ptr    <= {hi_l, rom_data, 1'b1};
        rom_cs <= 1'b0;
        dout   <= snd_l;
        cs     <= 1'b1;
      end
      if (req_drq) begin
        rom_addr <= ptr;
        rom_cs   <= 1'b1;
      end
      if (got_byte) begin
        dout   <= rom_data;
        rom_cs <= 1'b0;
        ptr    <= ptr + 17'd1;
      end
      if (fin) cs <= 1'b0;
    end
  end

  jt7759_strobe #(.WRW(WRW)) u_stn (
    .clk  (clk),
    .rstn (rstn),
    .fire (got_lo),
    .clr  (stop | tmo),
    .n    (stn),
    .last (stn_last)
  );

  jt7759_strobe #(.WRW(WRW)) u_wrn (
    .clk  (clk),
    .rstn (rstn),
    .fire (got_byte),
    .clr  (stop | tmo),
    .n    (wrn),
    .last (wrn_last)
  );

endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: table of sample transfers against a ROM and chip
// model, plus directed stop, watchdog and mid-transfer reset sequences.
module tb_jt7759_feeder;

  localparam int WRW = 4;

  logic        clk, rstn, play, stop, drqn, busyn, rom_ok;
  logic [7:0]  snd, rom_data, dout;
  logic        busy, err, cs, stn, wrn, rom_cs;
  logic [16:0] rom_addr;

  jt7759_feeder #(.WRW(WRW), .TOW(16)) dut (
    .clk(clk), .rstn(rstn), .play(play), .snd(snd), .stop(stop),
    .busy(busy), .err(err), .cs(cs), .stn(stn), .wrn(wrn), .dout(dout),
    .drqn(drqn), .busyn(busyn), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  snd;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          ndrq;
    logic [16:0] exp_tbl;
    logic [16:0] exp_ptr;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  mem [0:131071];
  int          total = 0, bad = 0;

  logic [16:0] addr_q [$];
  int          stn_w_q [$], wr_w_q [$];
  logic [7:0]  stn_d_q [$], wr_d_q [$];
  int          both_low = 0, dout_moved = 0, addr_moved = 0;
  int          chip_ndrq = 0;
  logic        chip_en, rom_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " cs"}, 32'(cs), 32'd0);
    chk({tag, " stn"}, 32'(stn), 32'd1);
    chk({tag, " wrn"}, 32'(wrn), 32'd1);
    chk({tag, " dout"}, 32'(dout), 32'd0);
    chk({tag, " rom_cs"}, 32'(rom_cs), 32'd0);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  // ROM responder, chip model and protocol monitor share one process for ordering
  initial begin
    int c_st, c_left, c_gap, stn_run, wr_run;
    logic prev_low, prev_cs;
    logic [7:0] prev_dout, stn_dout, wr_dout;
    logic [16:0] prev_addr;
    c_st = 0; c_left = 0; c_gap = 0; stn_run = 0; wr_run = 0;
    prev_low = 1'b0; prev_cs = 1'b0; prev_dout = 8'd0; prev_addr = 17'd0;
    stn_dout = 8'd0; wr_dout = 8'd0;
    drqn = 1'b1; busyn = 1'b1; rom_ok = 1'b0; rom_data = 8'd0;
    forever begin
      @(negedge clk);
      if (!stn && !wrn) both_low++;
      if (prev_low && dout !== prev_dout) dout_moved++;
      if (rom_cs && prev_cs && rom_addr !== prev_addr) addr_moved++;
      if (rom_cs && !prev_cs) addr_q.push_back(rom_addr);
      if (!stn) begin
        if (stn_run == 0) stn_dout = dout;
        stn_run++;
      end else if (stn_run != 0) begin
        stn_w_q.push_back(stn_run); stn_d_q.push_back(stn_dout); stn_run = 0;
      end
      if (!wrn) begin
        if (wr_run == 0) wr_dout = dout;
        wr_run++;
      end else if (wr_run != 0) begin
        wr_w_q.push_back(wr_run); wr_d_q.push_back(wr_dout); wr_run = 0;
      end
      prev_low  = !stn || !wrn;
      prev_dout = dout;
      rom_ok    = rom_cs && prev_cs && !rom_hold;
      rom_data  = mem[rom_addr];
      prev_cs   = rom_cs;
      prev_addr = rom_addr;
      if (!chip_en) begin
        c_st = 0; drqn = 1'b1; busyn = 1'b1;
      end else begin
        case (c_st)
          0: if (!stn) c_st = 1;
          1: if (stn) begin busyn = 1'b0; c_left = chip_ndrq; c_gap = 2; c_st = 2; end
          2: if (c_gap != 0) c_gap--;
             else if (c_left != 0) begin drqn = 1'b0; c_st = 3; end
             else begin busyn = 1'b1; c_st = 0; end
          3: if (!wrn) c_st = 4;
          4: if (wrn) begin drqn = 1'b1; c_left--; c_gap = 2; c_st = 2; end
          default: c_st = 0;
        endcase
      end
    end
  end

  task automatic clear_logs();
    addr_q.delete(); stn_w_q.delete(); stn_d_q.delete();
    wr_w_q.delete(); wr_d_q.delete();
  endtask

  task automatic start_play(input logic [7:0] s);
    @(negedge clk); snd = s; play = 1'b1;
    @(negedge clk); play = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int n;
    logic [16:0] a;
    v = vecs[i];
    mem[v.exp_tbl] = v.hi;
    mem[17'(v.exp_tbl + 17'd1)] = v.lo;
    chip_ndrq = v.ndrq;
    clear_logs();
    start_play(v.snd);
    chk($sformatf("v%0d busy after play", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d table rom_cs", i), 32'(rom_cs), 32'd1);
    chk($sformatf("v%0d table addr", i), 32'(rom_addr), 32'(v.exp_tbl));
    chk($sformatf("v%0d err cleared", i), 32'(err), 32'd0);
    // play while busy must be ignored
    snd = ~v.snd; play = 1'b1;
    @(negedge clk); play = 1'b0; snd = 8'd0;
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    chk($sformatf("v%0d finished", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d cs released", i), 32'(cs), 32'd0);
    chk($sformatf("v%0d stn pulses", i), 32'(stn_w_q.size()), 32'd1);
    chk($sformatf("v%0d stn width", i), (stn_w_q.size() > 0) ? 32'(stn_w_q[0]) : 32'hFFFF, 32'(WRW));
    chk($sformatf("v%0d stn dout", i), (stn_d_q.size() > 0) ? 32'(stn_d_q[0]) : 32'hFFFF, 32'(v.snd));
    chk($sformatf("v%0d rom reads", i), 32'(addr_q.size()), 32'(2 + v.ndrq));
    chk($sformatf("v%0d tbl hi addr", i), (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hFFFFF, 32'(v.exp_tbl));
    chk($sformatf("v%0d tbl lo addr", i), (addr_q.size() > 1) ? 32'(addr_q[1]) : 32'hFFFFF, 32'(17'(v.exp_tbl + 17'd1)));
    chk($sformatf("v%0d wrn pulses", i), 32'(wr_w_q.size()), 32'(v.ndrq));
    for (int k = 0; k < v.ndrq; k++) begin
      a = 17'(v.exp_ptr + 17'(k));
      chk($sformatf("v%0d fetch%0d addr", i, k), (addr_q.size() > 2 + k) ? 32'(addr_q[2 + k]) : 32'hFFFFF, 32'(a));
      chk($sformatf("v%0d wr%0d width", i, k), (wr_w_q.size() > k) ? 32'(wr_w_q[k]) : 32'hFFFF, 32'(WRW));
      chk($sformatf("v%0d wr%0d data", i, k), (wr_d_q.size() > k) ? 32'(wr_d_q[k]) : 32'hFFFF, 32'(mem[a]));
    end
  endtask

  initial begin
    int n;
    logic pw, found;
    rstn = 1'b0; play = 1'b0; stop = 1'b0; snd = 8'd0;
    chip_en = 1'b0; rom_hold = 1'b0;
    for (int a = 0; a < 131072; a++) mem[a] = 8'(a * 37 + 11);
    vecs[0] = '{snd: 8'h03, hi: 8'h01, lo: 8'h20, ndrq: 3, exp_tbl: 17'h0000B, exp_ptr: 17'h00241};
    vecs[1] = '{snd: 8'hFF, hi: 8'hFF, lo: 8'hFF, ndrq: 2, exp_tbl: 17'h00203, exp_ptr: 17'h1FFFF};
    vecs[2] = '{snd: 8'h00, hi: 8'h00, lo: 8'h10, ndrq: 1, exp_tbl: 17'h00005, exp_ptr: 17'h00021};
    vecs[3] = '{snd: 8'h80, hi: 8'h0A, lo: 8'h00, ndrq: 0, exp_tbl: 17'h00105, exp_ptr: 17'h01401};

    repeat (3) @(negedge clk);
    check_reset("por");
    rstn = 1'b1; chip_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(i);

    // play and stop together in IDLE stays idle
    snd = 8'h03; play = 1'b1; stop = 1'b1;
    @(negedge clk); play = 1'b0; stop = 1'b0;
    chk("play+stop busy", 32'(busy), 32'd0);
    chk("play+stop rom_cs", 32'(rom_cs), 32'd0);

    // stop in the second WRITE cycle
    chip_ndrq = 3; clear_logs();
    start_play(8'h03);
    n = 0;
    while (wrn && n < 500) begin @(negedge clk); n++; end
    chk("stop reached write", 32'(wrn), 32'd0);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop wrn", 32'(wrn), 32'd1);
    chk("stop busy", 32'(busy), 32'd0);
    chk("stop cs", 32'(cs), 32'd0);
    chk("stop rom_cs", 32'(rom_cs), 32'd0);
    chk("stop err", 32'(err), 32'd0);
    chip_en = 1'b0;
    @(negedge clk); chip_en = 1'b1;
    chk("stop wrn width", (wr_w_q.size() > 0) ? 32'(wr_w_q[0]) : 32'hFFFF, 32'd2);
    run_vec(0);

    // ROM never answers in FETCH: watchdog expiry
    chip_ndrq = 1;
    start_play(8'h03);
    n = 0;
    while (!(rom_cs && rom_addr == 17'h00241) && n < 500) begin @(negedge clk); n++; end
    chk("tmo reached fetch", 32'(rom_cs && rom_addr == 17'h00241), 32'd1);
    rom_hold = 1'b1;
    n = 0;
    while (busy && n < 70000) begin @(negedge clk); n++; end
    chk("tmo cycles", 32'(n), 32'd65536);
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo wrn", 32'(wrn), 32'd1);
    chk("tmo stn", 32'(stn), 32'd1);
    chk("tmo cs", 32'(cs), 32'd0);
    chk("tmo rom_cs", 32'(rom_cs), 32'd0);
    chip_en = 1'b0; rom_hold = 1'b0;
    @(negedge clk); chip_en = 1'b1;
    run_vec(2);

    // asynchronous reset while in RELEASE
    chip_ndrq = 3;
    start_play(8'h03);
    n = 0; pw = 1'b1; found = 1'b0;
    while (!found && n < 500) begin
      @(negedge clk); n++;
      if (wrn && !pw) found = 1'b1;
      pw = wrn;
    end
    chk("rst reached release", 32'(found), 32'd1);
    #2 rstn = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk); chip_en = 1'b0;
    @(negedge clk); rstn = 1'b1; chip_en = 1'b1;
    @(negedge clk);
    chk("post rst stn", 32'(stn), 32'd1);
    chk("post rst wrn", 32'(wrn), 32'd1);
    run_vec(0);

    chk("stn/wrn overlap", 32'(both_low), 32'd0);
    chk("dout stability", 32'(dout_moved), 32'd0);
    chk("rom_addr stability", 32'(addr_moved), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
